// File: rtl/lehmer_prng_mc_if.sv
// Bundles the control, seed and result-handshake signals of lehmer_prng_mc.
//   master : driver side (seed/control block and output consumer).
//   slave  : the generator itself.
// Parameters: WIDTH (state width), CW (channel index width).
// LEHMER_PRNG_STATS_EN adds gen_count (per-channel transfer count for out_ch).
interface lehmer_prng_mc_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 2
);
  logic             start;
  logic [CW-1:0]    ch_sel;
  logic             cont;
  logic             seed_we;
  logic [CW-1:0]    seed_ch;
  logic [WIDTH-1:0] seed_data;
  logic             seed_err;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_ch;
`ifdef LEHMER_PRNG_STATS_EN
  logic [15:0]      gen_count;

  modport master (
    output start, ch_sel, cont, seed_we, seed_ch, seed_data, out_ready,
    input  seed_err, busy, out_valid, out_data, out_ch, gen_count
  );
  modport slave (
    input  start, ch_sel, cont, seed_we, seed_ch, seed_data, out_ready,
    output seed_err, busy, out_valid, out_data, out_ch, gen_count
  );
`else
  modport master (
    output start, ch_sel, cont, seed_we, seed_ch, seed_data, out_ready,
    input  seed_err, busy, out_valid, out_data, out_ch
  );
  modport slave (
    input  start, ch_sel, cont, seed_we, seed_ch, seed_data, out_ready,
    output seed_err, busy, out_valid, out_data, out_ch
  );
`endif
endinterface

// File: rtl/lehmer_prng_mc.sv
// Multi-channel Park-Miller / Lehmer generator: s' = (A * s) mod M via Schrage's
// decomposition (s = hi*Q + lo, s' = A*lo - R*hi, + M if negative).
// CHANNELS state registers share one datapath: serial restoring divider (WIDTH
// cycles), multiply, subtract and fix-up stages, then a valid/ready output.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus.slave  : start/ch_sel/cont control, seed write (seed_we/seed_ch/seed_data,
//                seed_err pulse), busy, out_valid/out_ready/out_data/out_ch
// Optional: `define LEHMER_PRNG_STATS_EN adds per-channel 16-bit transfer counters
// and the bus.gen_count output.
module lehmer_prng_mc #(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     CHANNELS = 4,
  parameter longint unsigned A        = 16807,
  parameter longint unsigned M        = 2147483647
) (
  input logic             clk,
  input logic             rst,
  lehmer_prng_mc_if.slave bus
);

  localparam int unsigned     CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned     DCW = $clog2(WIDTH + 1);
  localparam longint unsigned Q   = M / A;
  localparam longint unsigned R   = M % A;

  localparam logic [WIDTH-1:0]   QW  = WIDTH'(Q);
  localparam logic [WIDTH-1:0]   MW  = WIDTH'(M);
  localparam logic [2*WIDTH-1:0] AW2 = (2*WIDTH)'(A);
  localparam logic [2*WIDTH-1:0] RW2 = (2*WIDTH)'(R);

  // Schrage only bounds the intermediates when R < Q.
  if (R >= Q) begin : g_bad_rq
    $error("lehmer_prng_mc: R (M %% A) must be less than Q (M / A)");
  end
  if ((M >> WIDTH) != 0) begin : g_bad_m
    $error("lehmer_prng_mc: M must be below 2**WIDTH");
  end

  typedef enum logic [2:0] {StIdle, StDiv, StMul, StSub, StFix, StOut} state_e;

  state_e             st_q, st_d;
  logic [CW-1:0]      ch_q, ch_d, load_ch, next_ch;
  logic [DCW-1:0]     dcnt_q, dcnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d;
  logic [2*WIDTH-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [WIDTH:0]     t_q, t_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]      out_ch_q, out_ch_d;
  logic [WIDTH-1:0]   chan_q [CHANNELS];
  logic               seed_err_q, seed_err_d;
  logic               load, wb_en, xfer;

  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] diff;
  logic [WIDTH-2:0]   unused_diff_hi;
  logic [WIDTH-1:0]   fix_res;

  logic               ch_sel_ok, seed_ch_ok, seed_clash, seed_in_range, seed_store;
  logic [WIDTH-1:0]   seed_val;

  // Restoring divider step: shift next dividend bit into the partial remainder.
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign rem_sub = rem_sh[WIDTH-1:0] - QW;

  // |p1|,|p2| < M < 2**WIDTH, so WIDTH+1 bits of the difference carry the sign.
  assign diff           = p1_q - p2_q;
  assign unused_diff_hi = diff[2*WIDTH-1:WIDTH+1];

  // For negative t the true sum t+M lies in (0, M), so modulo-2**WIDTH add is exact.
  assign fix_res = t_q[WIDTH] ? (t_q[WIDTH-1:0] + MW) : t_q[WIDTH-1:0];

  assign next_ch   = (out_ch_q == CW'(CHANNELS - 1)) ? '0 : out_ch_q + CW'(1);
  assign ch_sel_ok = 32'(bus.ch_sel) < CHANNELS;

  // Seed write qualification.
  assign seed_ch_ok    = 32'(bus.seed_ch) < CHANNELS;
  assign seed_clash    = (st_q != StIdle) && (bus.seed_ch == ch_q);
  assign seed_in_range = (bus.seed_data != '0) && (bus.seed_data < MW);
  assign seed_store    = bus.seed_we && seed_ch_ok && !seed_clash;
  assign seed_val      = seed_in_range ? bus.seed_data : WIDTH'(1);
  assign seed_err_d    = bus.seed_we && (!seed_ch_ok || seed_clash || !seed_in_range);

  always_comb begin
    st_d       = st_q;
    ch_d       = ch_q;
    dcnt_d     = dcnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    t_d        = t_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    load       = 1'b0;
    load_ch    = ch_q;
    wb_en      = 1'b0;
    xfer       = 1'b0;

    case (st_q)
      StIdle: begin
        if (bus.start && ch_sel_ok) begin
          load    = 1'b1;
          load_ch = bus.ch_sel;
        end
      end
      StDiv: begin
        if (rem_sh >= {1'b0, QW}) begin
          rem_d = rem_sub;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        dcnt_d = dcnt_q + DCW'(1);
        if (dcnt_q == DCW'(WIDTH - 1)) begin
          st_d = StMul;
        end
      end
      StMul: begin
        // quo_q = s div Q, rem_q = s mod Q.
        p1_d = AW2 * {{WIDTH{1'b0}}, rem_q};
        p2_d = RW2 * {{WIDTH{1'b0}}, quo_q};
        st_d = StSub;
      end
      StSub: begin
        t_d  = diff[WIDTH:0];
        st_d = StFix;
      end
      StFix: begin
        out_data_d = fix_res;
        out_ch_d   = ch_q;
        wb_en      = 1'b1;
        st_d       = StOut;
      end
      StOut: begin
        if (bus.out_ready) begin
          xfer = 1'b1;
          if (bus.cont) begin
            load    = 1'b1;
            load_ch = next_ch;
          end else begin
            st_d = StIdle;
          end
        end
      end
      default: st_d = StIdle;
    endcase

    // Snapshot the selected channel into the divider.
    if (load) begin
      st_d   = StDiv;
      ch_d   = load_ch;
      quo_d  = chan_q[load_ch];
      rem_d  = '0;
      dcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= StIdle;
      ch_q       <= '0;
      dcnt_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      t_q        <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      seed_err_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      ch_q       <= ch_d;
      dcnt_q     <= dcnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      t_q        <= t_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      seed_err_q <= seed_err_d;
    end
  end

  // Seed store and writeback never target the same channel: a seed write to the
  // active channel is rejected while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        chan_q[c] <= WIDTH'(2 * c + 5);
      end
    end else begin
      if (seed_store) begin
        chan_q[bus.seed_ch] <= seed_val;
      end
      if (wb_en) begin
        chan_q[ch_q] <= fix_res;
      end
    end
  end

`ifdef LEHMER_PRNG_STATS_EN
  logic [15:0] gcnt_q [CHANNELS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        gcnt_q[c] <= '0;
      end
    end else begin
      if (xfer) begin
        gcnt_q[ch_q] <= gcnt_q[ch_q] + 16'd1;
      end
      if (seed_store) begin
        gcnt_q[bus.seed_ch] <= '0;
      end
    end
  end

  // Includes the result currently on offer.
  assign bus.gen_count = gcnt_q[out_ch_q] + 16'd1;
`endif

  assign bus.busy      = (st_q != StIdle);
  assign bus.out_valid = (st_q == StOut);
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.seed_err  = seed_err_q;

endmodule

// File: tb/tb_lehmer_prng_mc.sv
module tb_lehmer_prng_mc;
  localparam int unsigned     WIDTH    = 32;
  localparam int unsigned     CHANNELS = 4;
  localparam int unsigned     CW       = 2;
  localparam longint unsigned M        = 2147483647;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lehmer_prng_mc_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  lehmer_prng_mc #(
    .WIDTH(WIDTH),
    .CHANNELS(CHANNELS),
    .A(16807),
    .M(M)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int npass  = 0;
  int ntotal = 0;

  // Direct 64-bit reference: (16807 * s) mod M.
  function automatic longint unsigned lehmer(input longint unsigned s);
    return (s * 64'd16807) % M;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_valid(inout int lat);
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Request one step; returns at the first negedge showing out_valid.
  // lat counts edges with the accepting edge as 1.
  task automatic run_step(input int ch, output int lat);
    bus.ch_sel = CW'(ch);
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    wait_valid(lat);
  endtask

  task automatic seed_write(input int ch, input longint unsigned d, input logic exp_err,
                            input string tag);
    bus.seed_we   = 1'b1;
    bus.seed_ch   = CW'(ch);
    bus.seed_data = WIDTH'(d);
    @(negedge clk);
    bus.seed_we = 1'b0;
    check({tag, " seed_err"}, longint'(bus.seed_err), longint'(exp_err));
  endtask

  typedef struct {
    logic            seed_we;
    int              seed_ch;
    longint unsigned seed_data;
    logic            exp_err;
    int              start_ch;
    longint unsigned exp_data;
    int              exp_gc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int              lat;
    longint unsigned s0;
    longint unsigned mdl[4];
    longint unsigned after_rst[4];
    longint unsigned held;
    int              k;
    int              exp_ch;
    int              budget;
    logic            seen;
    logic            rdy;

    vecs[0] = '{1'b0, 0, 0,                1'b0, 3, 184877,     1};
    vecs[1] = '{1'b0, 0, 0,                1'b0, 0, 84035,      1};
    vecs[2] = '{1'b1, 0, 1,                1'b0, 0, 16807,      1};
    vecs[3] = '{1'b0, 0, 0,                1'b0, 0, 282475249,  2};
    vecs[4] = '{1'b0, 0, 0,                1'b0, 0, 1622650073, 3};
    vecs[5] = '{1'b1, 1, 2147483646,       1'b0, 1, 2147466840, 1};
    vecs[6] = '{1'b1, 2, 0,                1'b1, 2, 16807,      1};
    vecs[7] = '{1'b1, 2, 64'h8000_0000,    1'b1, 2, 16807,      1};
    vecs[8] = '{1'b1, 3, 2147483647,       1'b1, 3, 16807,      1};
    vecs[9] = '{1'b0, 0, 0,                1'b0, 1, 1865008398, 2};
    after_rst = '{84035, 117649, 151263, 184877};

    bus.start     = 1'b0;
    bus.ch_sel    = '0;
    bus.cont      = 1'b0;
    bus.seed_we   = 1'b0;
    bus.seed_ch   = '0;
    bus.seed_data = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("reset busy",      longint'(bus.busy),      0);
    check("reset out_valid", longint'(bus.out_valid), 0);
    check("reset out_data",  longint'(bus.out_data),  0);
    check("reset out_ch",    longint'(bus.out_ch),    0);
    check("reset seed_err",  longint'(bus.seed_err),  0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].seed_we) begin
        seed_write(vecs[i].seed_ch, vecs[i].seed_data, vecs[i].exp_err,
                   $sformatf("v%0d", i));
      end
      run_step(vecs[i].start_ch, lat);
      check($sformatf("v%0d latency", i), lat, 36);
      check($sformatf("v%0d out_data", i), longint'(bus.out_data), longint'(vecs[i].exp_data));
      check($sformatf("v%0d out_ch", i), longint'(bus.out_ch), vecs[i].start_ch);
`ifdef LEHMER_PRNG_STATS_EN
      check($sformatf("v%0d gen_count", i), longint'(bus.gen_count), vecs[i].exp_gc);
`endif
      @(negedge clk);
      check($sformatf("v%0d valid drop", i), longint'(bus.out_valid), 0);
      check($sformatf("v%0d idle", i), longint'(bus.busy), 0);
    end

    // Start and seed writes while busy: start ignored, seed to active channel rejected,
    // seed to another channel accepted.
    s0 = 1622650073;
    bus.ch_sel = 0;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    repeat (3) begin
      @(negedge clk);
      lat++;
    end
    bus.start     = 1'b1;
    bus.ch_sel    = 1;
    bus.seed_we   = 1'b1;
    bus.seed_ch   = 0;
    bus.seed_data = 12345;
    @(negedge clk);
    lat++;
    bus.start   = 1'b0;
    bus.seed_we = 1'b0;
    check("busy seed active ch seed_err", longint'(bus.seed_err), 1);
    bus.seed_we   = 1'b1;
    bus.seed_ch   = 2;
    bus.seed_data = 100;
    @(negedge clk);
    lat++;
    bus.seed_we = 1'b0;
    check("busy seed other ch seed_err", longint'(bus.seed_err), 0);
    wait_valid(lat);
    check("busy latency", lat, 36);
    check("busy out_data", longint'(bus.out_data), longint'(lehmer(s0)));
    check("busy out_ch", longint'(bus.out_ch), 0);
    @(negedge clk);
    check("ignored start idle", longint'(bus.busy), 0);
    run_step(2, lat);
    check("other ch seed out_data", longint'(bus.out_data), 1680700);
    @(negedge clk);
    run_step(0, lat);
    check("active ch kept out_data", longint'(bus.out_data), longint'(lehmer(lehmer(s0))));
    @(negedge clk);

    // Reset in the middle of a divide.
    run_step(1, lat);
    @(negedge clk);
    bus.ch_sel = 1;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst busy",      longint'(bus.busy),      0);
    check("mid rst out_valid", longint'(bus.out_valid), 0);
    check("mid rst out_data",  longint'(bus.out_data),  0);
    check("mid rst out_ch",    longint'(bus.out_ch),    0);
    for (int c = 0; c < 4; c++) begin
      run_step(c, lat);
      check($sformatf("mid rst ch%0d out_data", c), longint'(bus.out_data),
            longint'(after_rst[c]));
      @(negedge clk);
    end

    // Continuous round-robin with random back-pressure.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl    = '{5, 7, 9, 11};
    k      = 0;
    exp_ch = 0;
    budget = 0;
    seen   = 1'b0;
    held   = 0;
    bus.cont      = 1'b1;
    bus.out_ready = 1'b0;
    bus.ch_sel    = 0;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (k < 12 && budget < 3000) begin
      if (bus.out_valid) begin
        if (!seen) begin
          check($sformatf("cont%0d out_data", k), longint'(bus.out_data),
                longint'(lehmer(mdl[exp_ch])));
          check($sformatf("cont%0d out_ch", k), longint'(bus.out_ch), exp_ch);
          held = bus.out_data;
          seen = 1'b1;
        end else begin
          check($sformatf("cont%0d stall data", k), longint'(bus.out_data), longint'(held));
          check($sformatf("cont%0d stall ch", k), longint'(bus.out_ch), exp_ch);
        end
        rdy = 1'($urandom_range(0, 1));
        if (k == 11) bus.cont = 1'b0;
        bus.out_ready = rdy;
        if (rdy) begin
          mdl[exp_ch] = lehmer(mdl[exp_ch]);
          exp_ch      = (exp_ch + 1) % 4;
          k++;
          seen = 1'b0;
        end
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      budget++;
      if (k > 0 && k < 12 && !seen && !bus.out_valid) begin
        check($sformatf("cont%0d busy kept", k), longint'(bus.busy), 1);
      end
    end
    check("cont transfers", k, 12);
    check("cont stop idle", longint'(bus.busy), 0);
    bus.out_ready = 1'b1;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
